// File: rtl/rtc_bus_sequencer.sv
// Single-byte read/write sequencer for a multiplexed-bus RTC chip.
// Runs address phase, inter-phase gap and data phase with programmable timing.
module rtc_bus_sequencer #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_GAP   = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       ad,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in
);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim_m1;
  logic             last;
  logic             rw_q;
  logic [7:0]       addr_q, wdata_q, addr_n;
  logic             lat_en, capture;
  logic             addr_ph, data_ph;

  logic             busy_d, done_d, cs_n_d, ad_d, rd_n_d, wr_n_d, bus_oe_d;
  logic [7:0]       bus_out_d, rdata_d;

  // Terminal count of the current timed state
  always_comb begin
    lim_m1 = '0;
    case (state_q)
      A_SETUP, D_SETUP:   lim_m1 = CNT_W'(T_SETUP - 1);
      A_STROBE, D_STROBE: lim_m1 = CNT_W'(T_PULSE - 1);
      A_HOLD, D_HOLD:     lim_m1 = CNT_W'(T_HOLD - 1);
      GAP:                lim_m1 = CNT_W'(T_GAP - 1);
      default:            lim_m1 = '0;
    endcase
  end

  assign last = (cnt_q == lim_m1);

  // Next-state and next-output logic; outputs are decoded from the next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    lat_en    = 1'b0;
    capture   = 1'b0;
    addr_n    = addr_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    cs_n_d    = 1'b1;
    ad_d      = 1'b0;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    bus_oe_d  = 1'b0;
    bus_out_d = bus_out;
    rdata_d   = rdata;
    addr_ph   = 1'b0;
    data_ph   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          lat_en  = 1'b1;
          state_d = A_SETUP;
        end
      end
      A_SETUP:  if (last) state_d = A_STROBE; else cnt_d = cnt_q + CNT_W'(1);
      A_STROBE: if (last) state_d = A_HOLD;   else cnt_d = cnt_q + CNT_W'(1);
      A_HOLD:   if (last) state_d = GAP;      else cnt_d = cnt_q + CNT_W'(1);
      GAP:      if (last) state_d = D_SETUP;  else cnt_d = cnt_q + CNT_W'(1);
      D_SETUP:  if (last) state_d = D_STROBE; else cnt_d = cnt_q + CNT_W'(1);
      D_STROBE: begin
        if (last) begin
          state_d = D_HOLD;
          capture = rw_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      D_HOLD:   if (last) state_d = DONE;     else cnt_d = cnt_q + CNT_W'(1);
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (lat_en) addr_n = addr;
    if (capture) rdata_d = bus_in;

    addr_ph = (state_d == A_SETUP) || (state_d == A_STROBE) || (state_d == A_HOLD);
    data_ph = (state_d == D_SETUP) || (state_d == D_STROBE) || (state_d == D_HOLD);

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    cs_n_d = !(addr_ph || data_ph);
    ad_d   = data_ph;
    wr_n_d = !((state_d == A_STROBE) || ((state_d == D_STROBE) && !rw_q));
    rd_n_d = !((state_d == D_STROBE) && rw_q);

    // The address is always written; data is driven only on writes
    if (addr_ph) begin
      bus_oe_d  = 1'b1;
      bus_out_d = addr_n;
    end else if (data_ph && !rw_q) begin
      bus_oe_d  = 1'b1;
      bus_out_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
      cs_n    <= 1'b1;
      ad      <= 1'b0;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      bus_out <= 8'h00;
      bus_oe  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (lat_en) begin
        rw_q    <= rw;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      busy    <= busy_d;
      done    <= done_d;
      rdata   <= rdata_d;
      cs_n    <= cs_n_d;
      ad      <= ad_d;
      rd_n    <= rd_n_d;
      wr_n    <= wr_n_d;
      bus_out <= bus_out_d;
      bus_oe  <= bus_oe_d;
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: default-timing and minimum-timing instances driven in
// lockstep, each compared every cycle against a transaction-offset model.
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, rw;
  logic [7:0] addr, wdata, bus_in;

  logic       a_busy, a_done, a_cs_n, a_ad, a_rd_n, a_wr_n, a_bus_oe;
  logic [7:0] a_rdata, a_bus_out;
  logic       b_busy, b_done, b_cs_n, b_ad, b_rd_n, b_wr_n, b_bus_oe;
  logic [7:0] b_rdata, b_bus_out;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  rtc_bus_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(a_busy), .done(a_done), .rdata(a_rdata), .cs_n(a_cs_n), .ad(a_ad),
    .rd_n(a_rd_n), .wr_n(a_wr_n), .bus_out(a_bus_out), .bus_oe(a_bus_oe), .bus_in(bus_in)
  );

  rtc_bus_sequencer #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(b_busy), .done(b_done), .rdata(b_rdata), .cs_n(b_cs_n), .ad(b_ad),
    .rd_n(b_rd_n), .wr_n(b_wr_n), .bus_out(b_bus_out), .bus_oe(b_bus_oe), .bus_in(bus_in)
  );

  typedef struct {
    int s, p, h, g;
    bit act;
    int k;          // cycles since the accepting edge (1 = first A_SETUP cycle)
    bit rw;
    logic [7:0] a, w, rd, bo;
  } mdl_t;

  typedef struct packed {
    logic busy, done;
    logic [7:0] rdata;
    logic cs_n, ad, rd_n, wr_n;
    logic [7:0] bus_out;
    logic bus_oe;
  } obs_t;

  mdl_t ma, mb;
  int t_cyc;
  int a_done_cnt, a_done_at, b_done_cnt;
  int a_done_q[$], b_done_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%0h exp=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_init(int s, int p, int h, int g);
    mdl_t m;
    m.s = s; m.p = p; m.h = h; m.g = g;
    m.act = 0; m.k = 0; m.rw = 0;
    m.a = 8'h00; m.w = 8'h00; m.rd = 8'h00; m.bo = 8'h00;
    return m;
  endfunction

  // Expected pin values from the transaction offset alone
  function automatic obs_t expect_of(mdl_t m);
    obs_t e;
    int ae, ge, de, j;
    bit strobe;
    e.busy = 0; e.done = 0; e.rdata = m.rd; e.cs_n = 1; e.ad = 0;
    e.rd_n = 1; e.wr_n = 1; e.bus_out = m.bo; e.bus_oe = 0;
    if (m.act) begin
      e.busy = 1;
      ae = m.s + m.p + m.h;
      ge = ae + m.g;
      de = ge + ae;
      if (m.k <= ae) begin
        e.cs_n = 0; e.bus_oe = 1;
        e.wr_n = !(m.k > m.s && m.k <= m.s + m.p);
      end else if (m.k <= ge) begin
        e.cs_n = 1;
      end else if (m.k <= de) begin
        j = m.k - ge;
        strobe = (j > m.s && j <= m.s + m.p);
        e.cs_n = 0; e.ad = 1;
        if (m.rw) e.rd_n = !strobe;
        else begin
          e.bus_oe = 1; e.wr_n = !strobe;
        end
      end else begin
        e.done = 1;
      end
    end
    return e;
  endfunction

  // Advance the model across one clock edge with the inputs present at that edge
  function automatic mdl_t tick(mdl_t m, logic rst, logic st, logic r,
                                logic [7:0] a, logic [7:0] w, logic [7:0] bi);
    int ge, total;
    ge = m.s + m.p + m.h + m.g;
    total = 2 * (m.s + m.p + m.h) + m.g + 1;
    if (rst) begin
      m.act = 0; m.k = 0; m.rd = 8'h00; m.bo = 8'h00;
    end else if (!m.act) begin
      if (st) begin
        m.act = 1; m.k = 1; m.rw = r; m.a = a; m.w = w; m.bo = a;
      end
    end else begin
      if (m.rw && m.k == ge + m.s + m.p) m.rd = bi;
      if (m.k == total) begin
        m.act = 0; m.k = 0;
      end else begin
        m.k++;
        if (!m.rw && m.k == ge + 1) m.bo = m.w;
      end
    end
    return m;
  endfunction

  task automatic check_all(input string who, input obs_t o, input obs_t e);
    chk({who, ".busy"},    8'(o.busy),   8'(e.busy));
    chk({who, ".done"},    8'(o.done),   8'(e.done));
    chk({who, ".rdata"},   o.rdata,      e.rdata);
    chk({who, ".cs_n"},    8'(o.cs_n),   8'(e.cs_n));
    chk({who, ".ad"},      8'(o.ad),     8'(e.ad));
    chk({who, ".rd_n"},    8'(o.rd_n),   8'(e.rd_n));
    chk({who, ".wr_n"},    8'(o.wr_n),   8'(e.wr_n));
    chk({who, ".bus_out"}, o.bus_out,    e.bus_out);
    chk({who, ".bus_oe"},  8'(o.bus_oe), 8'(e.bus_oe));
  endtask

  // One clock cycle: drive inputs, advance models, sample after the edge, compare
  task automatic cyc(input logic rst, input logic st, input logic r,
                     input logic [7:0] a, input logic [7:0] w, input logic [7:0] bi);
    obs_t oa, ob;
    reset = rst; start = st; rw = r; addr = a; wdata = w; bus_in = bi;
    ma = tick(ma, rst, st, r, a, w, bi);
    mb = tick(mb, rst, st, r, a, w, bi);
    @(posedge clk);
    #1;
    t_cyc++;
    oa = '{a_busy, a_done, a_rdata, a_cs_n, a_ad, a_rd_n, a_wr_n, a_bus_out, a_bus_oe};
    ob = '{b_busy, b_done, b_rdata, b_cs_n, b_ad, b_rd_n, b_wr_n, b_bus_out, b_bus_oe};
    check_all("a", oa, expect_of(ma));
    check_all("b", ob, expect_of(mb));
    if (a_done) begin a_done_cnt++; a_done_at = t_cyc; a_done_q.push_back(t_cyc); end
    if (b_done) begin b_done_cnt++; b_done_q.push_back(t_cyc); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Bus invariants, checked on every falling edge for both instances
  logic rst_last = 1'b1;
  logic a_ad_p, b_ad_p, a_str_p, b_str_p;
  logic [7:0] a_bo_p, b_bo_p;
  bit inv_on = 0;

  always @(posedge clk) rst_last <= reset;

  always @(negedge clk) begin
    if (inv_on) begin
      chk("inv.a.rd_wr", 8'(!a_rd_n && !a_wr_n), 8'h00);
      chk("inv.a.cs",    8'(a_cs_n && (!a_rd_n || !a_wr_n)), 8'h00);
      chk("inv.a.oe_rd", 8'(!a_rd_n && a_bus_oe), 8'h00);
      chk("inv.b.rd_wr", 8'(!b_rd_n && !b_wr_n), 8'h00);
      chk("inv.b.cs",    8'(b_cs_n && (!b_rd_n || !b_wr_n)), 8'h00);
      chk("inv.b.oe_rd", 8'(!b_rd_n && b_bus_oe), 8'h00);
      if (!rst_last) begin
        chk("inv.a.chg", 8'(((a_ad != a_ad_p) || (a_bus_out != a_bo_p)) &&
                            !(a_str_p && a_rd_n && a_wr_n)), 8'h00);
        chk("inv.b.chg", 8'(((b_ad != b_ad_p) || (b_bus_out != b_bo_p)) &&
                            !(b_str_p && b_rd_n && b_wr_n)), 8'h00);
      end
    end
    a_ad_p = a_ad; a_bo_p = a_bus_out; a_str_p = a_rd_n && a_wr_n;
    b_ad_p = b_ad; b_bo_p = b_bus_out; b_str_p = b_rd_n && b_wr_n;
  end

  int cnt0, wr_low;
  int prev;

  initial begin
    ma = mdl_init(2, 4, 2, 4);
    mb = mdl_init(1, 1, 1, 1);
    t_cyc = 0; a_done_cnt = 0; a_done_at = -1; b_done_cnt = 0;
    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; bus_in = 8'h00;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    inv_on = 1;
    chk("rst.rdata", a_rdata, 8'h00);
    chk("rst.cs_n", 8'(a_cs_n), 8'h01);
    chk("rst.busy", 8'(a_busy), 8'h00);
    idle(2);

    // Write 0x21 <- 0x59
    t_cyc = 0; cnt0 = a_done_cnt; wr_low = 0;
    cyc(1'b0, 1'b1, 1'b0, 8'h21, 8'h59, 8'($urandom));
    for (int i = 0; i < 22; i++) begin
      cyc(1'b0, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      if (!a_wr_n) wr_low++;
    end
    chk("wr.done_cycle", 8'(a_done_at), 8'd21);
    chk("wr.done_count", 8'(a_done_cnt - cnt0), 8'd1);
    chk("wr.strobe_cycles", 8'(wr_low), 8'd8);
    chk("wr.rdata_kept", a_rdata, 8'h00);
    idle(2);

    // Read 0x22, bus returns 0x37
    t_cyc = 0;
    cyc(1'b0, 1'b1, 1'b1, 8'h22, 8'($urandom), 8'h37);
    for (int i = 0; i < 22; i++) begin
      cyc(1'b0, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 8'h37);
      if (t_cyc == 19) chk("rd.rdata_c19", a_rdata, 8'h37);
    end
    chk("rd.done_cycle", 8'(a_done_at), 8'd21);
    idle(2);

    // Start pulses during a transaction are ignored
    t_cyc = 0; cnt0 = a_done_cnt;
    cyc(1'b0, 1'b1, 1'b0, 8'h10, 8'hA5, 8'($urandom));
    for (int i = 1; i < 32; i++)
      cyc(1'b0, (i == 5 || i == 21), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    chk("ign.done_count", 8'(a_done_cnt - cnt0), 8'd1);
    idle(4);

    // Reset in cycle 16 of a write, then a fresh read
    t_cyc = 0; cnt0 = a_done_cnt;
    cyc(1'b0, 1'b1, 1'b0, 8'h30, 8'h44, 8'($urandom));
    for (int i = 1; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    cyc(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    chk("mid_rst.wr_n", 8'(a_wr_n), 8'h01);
    chk("mid_rst.busy", 8'(a_busy), 8'h00);
    idle(3);
    chk("mid_rst.no_done", 8'(a_done_cnt - cnt0), 8'd0);
    t_cyc = 0;
    cyc(1'b0, 1'b1, 1'b1, 8'h0B, 8'($urandom), 8'hC3);
    for (int i = 0; i < 22; i++) cyc(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'hC3);
    chk("mid_rst.read_done", 8'(a_done_at), 8'd21);
    chk("mid_rst.read_data", a_rdata, 8'hC3);
    idle(2);

    // Continuous start, alternating rw
    a_done_q.delete(); b_done_q.delete(); t_cyc = 0;
    for (int i = 0; i < 70; i++) cyc(1'b0, 1'b1, 1'(i), 8'($urandom), 8'($urandom), 8'($urandom));
    chk("b2b.b_first", 8'(b_done_q[0]), 8'd8);
    chk("b2b.a_first", 8'(a_done_q[0]), 8'd21);
    for (int i = 1; i < b_done_q.size(); i++) chk("b2b.b_period", 8'(b_done_q[i] - b_done_q[i-1]), 8'd9);
    for (int i = 1; i < a_done_q.size(); i++) chk("b2b.a_period", 8'(a_done_q[i] - a_done_q[i-1]), 8'd22);
    idle(25);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 60) == 0, ($urandom % 4) != 0, 1'($urandom),
          8'($urandom), 8'($urandom), 8'($urandom));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
